digit_serial_addsub: RTL and testbench
======================================

Name: digit_serial_addsub

Overview:
Multi-cycle parametrised adder/subtractor. Processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first, using one shared DIGIT-wide ripple carry chain and a registered inter-digit carry.
Trades latency for area in the arithmetic datapath. Uses a valid/ready handshake on the input and output sides.
Adds subtract mode, a signed-overflow flag and a zero flag, none of which the one-bit adder cells provide.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT (elaboration error otherwise)
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH; NDIG = WIDTH/DIGIT cycles per operation

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands valid
in_ready  out  1  block can accept an operation
A  in  WIDTH  operand A
B  in  WIDTH  operand B
Cin  in  1  carry-in, add mode only
sub  in  1  0: S=A+B+Cin; 1: S=A-B (A+~B+1, Cin ignored)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
S  out  WIDTH  result
Cout  out  1  carry out of MSB; in sub mode 1 = no borrow
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB
zero  out  1  S == 0

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (async assert, any state, including mid-RUN): state=IDLE, digit counter=0, carry reg=0, operand/result shift regs=0. Outputs: S=0, Cout=0, ovf=0, zero=0, out_valid=0, in_ready=1. Any in-flight operation is discarded.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture A, B^{WIDTH{sub}} and carry = sub ? 1 : Cin; counter=0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the current low DIGIT bits of A/B plus the carry reg feed the ripple chain.
  - At the edge:
    - the digit sum shifts into the result reg from the top;
    - A/B shift right by DIGIT;
    - the carry reg takes the chain carry-out;
    - counter increments.
  - When counter==NDIG-1 at the edge:
    - latch Cout = chain carry-out;
    - latch ovf = carry into the chain's MSB cell XOR chain carry-out;
    - go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - S, Cout, ovf and zero are held stable until the edge with out_ready=1, then go to IDLE.
  - Outputs keep their last values in IDLE; only out_valid drops.
- Latency and throughput: out_valid rises NDIG cycles after the accept edge. No same-cycle result/accept overlap, so max throughput is one operation per NDIG+2 cycles.
- Input handshake: in_valid is ignored outside IDLE. Operands need only be stable on the accept edge.
- zero is registered and computed from the final result value.
- DIGIT==WIDTH: NDIG=1, single RUN cycle; the counter may be zero-width-safe (minimum 1 bit).
- Carry behaviour:
  - Full wrap-around: S is modulo 2^WIDTH.
  - Add mode: carry propagates across digits exactly as a WIDTH-bit ripple adder would.
- out_ready high while not in DONE has no effect.

Decomposition:
- Package addsub_pkg holds:
  - state enum type (IDLE/RUN/DONE);
  - function ndig(WIDTH, DIGIT);
  - function cnt_w returning max(1,$clog2(NDIG)).
- One natural sub-module: ripple_adder_n (parameter N=DIGIT). Combinational chain of N one-bit full-adder cells.
  - Inputs: a[N], b[N], cin.
  - Outputs: s[N], cout, and c_msb (carry into bit N-1) for overflow detection.

Test Plan:
All scenarios use WIDTH=8, DIGIT=2 (NDIG=4) unless noted.
- Add with carry-in: A=0x3C, B=0x05, Cin=1, sub=0 -> S=0x42, Cout=0, ovf=0, zero=0; out_valid rises exactly 4 cycles after accept.
- Carry wrap: A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, ovf=0, zero=1.
- Signed overflow, add and sub:
  - A=0x7F, B=0x01 add -> S=0x80, Cout=0, ovf=1.
  - A=0x80, B=0x01 sub -> S=0x7F, Cout=1, ovf=1.
- Subtract with borrow: A=0x10, B=0x20, sub=1, Cin=1 (ignored) -> S=0xF0, Cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> S/flags unchanged, in_ready=0, new operands not taken. Then set out_ready=1 -> IDLE next cycle, next op accepted the cycle after.
- Reset mid-RUN: assert rst asynchronously after 2 RUN cycles -> all outputs 0 and in_ready=1 immediately. After release, A=0x01, B=0x01 -> S=0x02. Repeat the add scenario with DIGIT=8 (NDIG=1) -> same results, 1-cycle latency.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder/subtractor.
// Holds the FSM state type and the digit-count / counter-width functions.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit operation still needs a one-bit counter to compare against.
  function automatic int cnt_w(input int width, input int digit);
    int n;
    n = ndig(width, digit);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// Combinational N-bit ripple-carry chain built from one-bit full-adder cells.
// Also exposes the carry into the top cell so callers can detect signed overflow.
module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign s[i]           = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout  = w_carry[N];
  assign c_msb = w_carry[N-1];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per clock, LSB digit first,
// one shared ripple chain plus a registered inter-digit carry, valid/ready on both sides.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
  end

  state_t r_state;
  state_t w_nextState;

  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [DIGIT-1:0] w_digitSum;
  logic             w_chainCout;
  logic             w_chainCmsb;
  logic [WIDTH-1:0] w_sNext;
  logic             w_lastDigit;

  ripple_adder_n #(
    .N(DIGIT)
  ) u_chain (
    .a     (r_a[DIGIT-1:0]),
    .b     (r_b[DIGIT-1:0]),
    .cin   (r_carry),
    .s     (w_digitSum),
    .cout  (w_chainCout),
    .c_msb (w_chainCmsb)
  );

  // New digit enters the result register from the top so the LSB digit ends at bit 0.
  assign w_sNext     = (r_s >> DIGIT) | (WIDTH'(w_digitSum) << (WIDTH - DIGIT));
  assign w_lastDigit = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_lastDigit) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Subtraction is folded into capture: B is inverted and the chain starts with carry 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{sub}};
            r_carry <= sub ? 1'b1 : Cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_s     <= w_sNext;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_chainCout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_lastDigit) begin
            r_cout <= w_chainCout;
            r_ovf  <= w_chainCmsb ^ w_chainCout;
            r_zero <= (w_sNext == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench: drives an 8-bit, 2-bit-digit instance and an 8-bit, 8-bit-digit
// instance with the same operands and checks both against an integer reference model.
module tb_digit_serial_addsub;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic       sub;

  logic       inReady0, outValid0, cout0, ovf0, zero0;
  logic [7:0] s0;
  logic       inReady1, outValid1, cout1, ovf1, zero1;
  logic [7:0] s1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vecs[7];

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady0),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(outValid0), .out_ready(out_ready),
    .S(s0), .Cout(cout0), .ovf(ovf0), .zero(zero0)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady1),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(outValid1), .out_ready(out_ready),
    .S(s1), .Cout(cout1), .ovf(ovf1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain unsigned and signed integer arithmetic on the 8-bit operands.
  function automatic void refModel(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic subIn,
                                   output logic [7:0] s, output logic cout,
                                   output logic ovf, output logic zero);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int ur;
    int sr;
    if (!subIn) begin
      ur   = ua + ub + int'(cin);
      sr   = sa + sb + int'(cin);
      cout = (ur > 255);
    end else begin
      ur   = ua - ub;
      sr   = sa - sb;
      cout = (ua >= ub);
    end
    s    = ur[7:0];
    ovf  = (sr > 127) || (sr < -128);
    zero = (s == 8'h00);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Presents one operation and returns one time unit after the accept edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic subIn);
    @(negedge clk);
    A        = a;
    B        = b;
    Cin      = cin;
    sub      = subIn;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("inReadyAfterAccept", inReady0, 1'b0);
  endtask

  task automatic waitAndCheck(input string tag, input logic [7:0] eS, input logic eC,
                              input logic eO, input logic eZ);
    int lat0 = 0;
    int lat1 = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      if (outValid1 && (lat1 == 0)) lat1 = cyc;
      if (outValid0) begin
        lat0 = cyc;
        break;
      end
    end
    checkOutput({tag, " latency0"}, lat0, 4);
    checkOutput({tag, " latency1"}, lat1, 1);
    checkOutput({tag, " S0"}, s0, eS);
    checkOutput({tag, " Cout0"}, cout0, eC);
    checkOutput({tag, " ovf0"}, ovf0, eO);
    checkOutput({tag, " zero0"}, zero0, eZ);
    checkOutput({tag, " S1"}, s1, eS);
    checkOutput({tag, " Cout1"}, cout1, eC);
    checkOutput({tag, " ovf1"}, ovf1, eO);
    checkOutput({tag, " zero1"}, zero1, eZ);
  endtask

  task automatic releaseResult();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("outValidAfterRelease", outValid0, 1'b0);
    checkOutput("inReadyAfterRelease", inReady0, 1'b1);
  endtask

  initial begin
    logic [7:0] ra, rb, eS;
    logic       rc, rsub, eC, eO, eZ;

    vecs[0] = '{8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 8'h00;
    B         = 8'h00;
    Cin       = 1'b0;
    sub       = 1'b0;

    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset S", s0, 8'h00);
    checkOutput("reset Cout", cout0, 1'b0);
    checkOutput("reset ovf", ovf0, 1'b0);
    checkOutput("reset zero", zero0, 1'b0);
    checkOutput("reset outValid", outValid0, 1'b0);
    checkOutput("reset inReady", inReady0, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      waitAndCheck($sformatf("vec%0d", i), vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
      releaseResult();
    end

    $display("[TB] backpressure");
    applyStimulus(8'h3C, 8'h05, 1'b1, 1'b0);
    waitAndCheck("bp first", 8'h42, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    A        = 8'h11;
    B        = 8'h22;
    Cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp holdS", s0, 8'h42);
      checkOutput("bp holdValid", outValid0, 1'b1);
      checkOutput("bp holdInReady", inReady0, 1'b0);
      checkOutput("bp holdS1", s1, 8'h42);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp idleValid", outValid0, 1'b0);
    checkOutput("bp idleInReady", inReady0, 1'b1);
    checkOutput("bp idleS", s0, 8'h42);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp accepted", inReady0, 1'b0);
    waitAndCheck("bp second", 8'h33, 1'b0, 1'b0, 1'b0);
    releaseResult();

    $display("[TB] reset mid-run");
    applyStimulus(8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstRun S", s0, 8'h00);
    checkOutput("rstRun Cout", cout0, 1'b0);
    checkOutput("rstRun ovf", ovf0, 1'b0);
    checkOutput("rstRun zero", zero0, 1'b0);
    checkOutput("rstRun outValid", outValid0, 1'b0);
    checkOutput("rstRun inReady", inReady0, 1'b1);
    checkOutput("rstRun outValid1", outValid1, 1'b0);
    checkOutput("rstRun inReady1", inReady1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
    waitAndCheck("after reset", 8'h02, 1'b0, 1'b0, 1'b0);
    releaseResult();

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rc   = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      refModel(ra, rb, rc, rsub, eS, eC, eO, eZ);
      applyStimulus(ra, rb, rc, rsub);
      waitAndCheck($sformatf("rand%0d a=%0h b=%0h c=%0b sub=%0b", i, ra, rb, rc, rsub),
                   eS, eC, eO, eZ);
      releaseResult();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
